// File: rtl/sp_ram_pkg.sv
// ---------------------------------------------------------------------------
// sp_ram_pkg
// Types and constants shared by the single-port RAM initiator and the RAM
// wrapper. A response carries only read data. Write responses return all zeros.
// ---------------------------------------------------------------------------
package sp_ram_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int BE_WIDTH   = DATA_WIDTH / 8;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] rdata;
    } resp_t;

    // Builds the response word for a completed access. Writes return zero.
    function automatic resp_t make_resp(input logic is_write,
                                        input logic [DATA_WIDTH-1:0] rdata);
        resp_t r;
        if (is_write) begin
            r.rdata = {DATA_WIDTH{1'b0}};
        end else begin
            r.rdata = rdata;
        end
        return r;
    endfunction

endpackage

// File: rtl/sp_ram_initiator_checker.sv
// ---------------------------------------------------------------------------
// sp_ram_initiator_checker
// Protocol and occupancy properties for sp_ram_initiator.
// Ports: request channel of the initiator plus its internal FIFO push/full
// and outstanding-count signals.
// ---------------------------------------------------------------------------
module sp_ram_initiator_checker #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 32,
    parameter int RESP_DEPTH = 2,
    parameter int CW         = 2
) (
    input logic                    clk,
    input logic                    rstn_i,
    input logic                    req_i,
    input logic                    gnt_o,
    input logic [ADDR_WIDTH-1:0]   addr_i,
    input logic                    we_i,
    input logic [DATA_WIDTH/8-1:0] be_i,
    input logic [DATA_WIDTH-1:0]   wdata_i,
    input logic                    fifo_push,
    input logic                    fifo_full,
    input logic [CW-1:0]           count_q
);

    a_no_push_when_full: assert property (
        @(posedge clk) disable iff (!rstn_i) fifo_push |-> !fifo_full);

    a_count_in_range: assert property (
        @(posedge clk) disable iff (!rstn_i) count_q <= CW'(RESP_DEPTH));

    a_req_payload_stable: assert property (
        @(posedge clk) disable iff (!rstn_i)
        (req_i && !gnt_o) |=> (req_i && $stable(addr_i) && $stable(we_i)
                               && $stable(be_i) && $stable(wdata_i)));

endmodule

// File: rtl/sp_ram_resp_fifo.sv
// ---------------------------------------------------------------------------
// sp_ram_resp_fifo
// Circular-buffer response FIFO, DEPTH entries of resp_t.
// Ports:
//   clk, rstn_i   clock, async active-low reset
//   push, wdata   write an entry (caller guarantees not full)
//   pop           drop the head entry (caller guarantees not empty)
//   head          current head entry
//   full, empty   occupancy flags
// ---------------------------------------------------------------------------
module sp_ram_resp_fifo
    import sp_ram_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic  clk,
    input  logic  rstn_i,
    input  logic  push,
    input  resp_t wdata,
    input  logic  pop,
    output resp_t head,
    output logic  full,
    output logic  empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OW = $clog2(DEPTH + 1);

    resp_t           mem_r [DEPTH];
    logic [PW-1:0]   wr_ptr_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [OW-1:0]   occ_r;

    assign head  = mem_r[rd_ptr_r];
    assign full  = (occ_r == OW'(DEPTH));
    assign empty = (occ_r == {OW{1'b0}});

    // Storage, pointers and occupancy of the circular buffer.
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '{rdata: {DATA_WIDTH{1'b0}}};
            end
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            occ_r    <= {OW{1'b0}};
        end else begin
            if (push) begin
                mem_r[wr_ptr_r] <= wdata;
                if (wr_ptr_r == PW'(DEPTH - 1)) begin
                    wr_ptr_r <= {PW{1'b0}};
                end else begin
                    wr_ptr_r <= wr_ptr_r + PW'(1);
                end
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop) begin
                if (rd_ptr_r == PW'(DEPTH - 1)) begin
                    rd_ptr_r <= {PW{1'b0}};
                end else begin
                    rd_ptr_r <= rd_ptr_r + PW'(1);
                end
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            occ_r <= occ_r + OW'(push) - OW'(pop);
        end
    end

endmodule

// File: rtl/sp_ram_initiator.sv
// ---------------------------------------------------------------------------
// sp_ram_initiator
// Master side of the single-port RAM port. Core-style req/gnt requests are
// passed straight through to the RAM (read data one cycle after enable) and
// every granted request returns exactly one response over rvalid/rready.
// A small FIFO absorbs response backpressure. Responses stay in order.
// Ports:
//   clk, rstn_i                      clock, async active-low reset
//   req_i/gnt_o, addr_i, we_i,
//   be_i, wdata_i                    request channel (payload held until gnt)
//   rvalid_o/rready_i, rdata_o       response channel (writes return zero)
//   ram_en_o, ram_addr_o, ram_we_o,
//   ram_wdata_o, ram_be_o,
//   ram_rdata_i                      RAM wrapper interface
//   ram_bypass_en_o                  write-bypass control, tied low
// ---------------------------------------------------------------------------
module sp_ram_initiator #(
    parameter int RAM_SIZE   = 32768,
    parameter int ADDR_WIDTH = $clog2(RAM_SIZE),
    parameter int DATA_WIDTH = sp_ram_pkg::DATA_WIDTH,
    parameter int RESP_DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rstn_i,
    input  logic                    req_i,
    output logic                    gnt_o,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic                    we_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic                    rvalid_o,
    input  logic                    rready_i,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic                    ram_en_o,
    output logic [ADDR_WIDTH-1:0]   ram_addr_o,
    output logic [DATA_WIDTH-1:0]   ram_wdata_o,
    output logic                    ram_we_o,
    output logic [DATA_WIDTH/8-1:0] ram_be_o,
    input  logic [DATA_WIDTH-1:0]   ram_rdata_i,
    output logic                    ram_bypass_en_o
);

    import sp_ram_pkg::*;

    localparam int CW = $clog2(RESP_DEPTH + 1);

    // Outstanding responses: FIFO occupancy plus the one in its RAM cycle.
    logic [CW-1:0] count_q;
    logic          pending_q;
    logic          pending_we_q;

    resp_t         resp_data_s;
    resp_t         fifo_head_s;
    logic          fifo_full_s;
    logic          fifo_empty_s;
    logic          fifo_push_s;
    logic          fifo_pop_s;
    logic          resp_pop_s;

    // The grant looks only at registered occupancy, never at rready_i.
    assign gnt_o = req_i & (count_q < CW'(RESP_DEPTH));

    assign ram_en_o        = gnt_o;
    assign ram_addr_o      = addr_i;
    assign ram_wdata_o     = wdata_i;
    assign ram_be_o        = be_i;
    assign ram_we_o        = gnt_o & we_i;
    assign ram_bypass_en_o = 1'b0;

    assign rvalid_o   = pending_q | ~fifo_empty_s;
    assign resp_pop_s = rvalid_o & rready_i;

    // The pending response bypasses the FIFO only when nothing is queued ahead
    // of it and it is taken this cycle; otherwise it queues behind the head.
    assign fifo_push_s = pending_q & ~(fifo_empty_s & rready_i);
    assign fifo_pop_s  = ~fifo_empty_s & rready_i;

    // Selects the response word: FIFO head first, else the fall-through data.
    always_comb begin
        resp_data_s = make_resp(pending_we_q, ram_rdata_i);
        if (!fifo_empty_s) begin
            rdata_o = fifo_head_s.rdata;
        end else if (pending_q) begin
            rdata_o = resp_data_s.rdata;
        end else begin
            rdata_o = {DATA_WIDTH{1'b0}};
        end
    end

    // Tracks the request in its RAM cycle and the total outstanding count.
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            pending_q    <= 1'b0;
            pending_we_q <= 1'b0;
            count_q      <= {CW{1'b0}};
        end else begin
            pending_q    <= gnt_o;
            pending_we_q <= gnt_o & we_i;
            count_q      <= count_q + CW'(gnt_o) - CW'(resp_pop_s);
        end
    end

    sp_ram_resp_fifo #(
        .DEPTH (RESP_DEPTH)
    ) u_resp_fifo (
        .clk    (clk),
        .rstn_i (rstn_i),
        .push   (fifo_push_s),
        .wdata  (resp_data_s),
        .pop    (fifo_pop_s),
        .head   (fifo_head_s),
        .full   (fifo_full_s),
        .empty  (fifo_empty_s)
    );

endmodule

// File: tb/tb_sp_ram_initiator.sv
module tb_sp_ram_initiator;
    import sp_ram_pkg::*;

    logic        clk = 1'b0;
    logic        rstn_i = 1'b0;
    logic        req_i = 1'b0;
    logic        gnt_o;
    logic [14:0] addr_i = 15'h0;
    logic        we_i = 1'b0;
    logic [3:0]  be_i = 4'h0;
    logic [31:0] wdata_i = 32'h0;
    logic        rvalid_o;
    logic        rready_i = 1'b0;
    logic [31:0] rdata_o;
    logic        ram_en_o;
    logic [14:0] ram_addr_o;
    logic [31:0] ram_wdata_o;
    logic        ram_we_o;
    logic [3:0]  ram_be_o;
    logic [31:0] ram_rdata_i = 32'h0;
    logic        ram_bypass_en_o;

    always #5 clk = ~clk;

    sp_ram_initiator #(.RAM_SIZE(32768), .RESP_DEPTH(2)) dut (
        .clk(clk), .rstn_i(rstn_i), .req_i(req_i), .gnt_o(gnt_o),
        .addr_i(addr_i), .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i),
        .rvalid_o(rvalid_o), .rready_i(rready_i), .rdata_o(rdata_o),
        .ram_en_o(ram_en_o), .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o),
        .ram_we_o(ram_we_o), .ram_be_o(ram_be_o), .ram_rdata_i(ram_rdata_i),
        .ram_bypass_en_o(ram_bypass_en_o)
    );

    sp_ram_initiator_checker #(.ADDR_WIDTH(15), .DATA_WIDTH(32), .RESP_DEPTH(2), .CW(2)) chk (
        .clk(clk), .rstn_i(rstn_i), .req_i(req_i), .gnt_o(gnt_o),
        .addr_i(addr_i), .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i),
        .fifo_push(dut.fifo_push_s), .fifo_full(dut.fifo_full_s), .count_q(dut.count_q)
    );

    // RAM wrapper stand-in: byte-enabled write, registered read.
    logic [31:0] ram_mem [0:8191] = '{default: 32'h0};
    logic [31:0] ref_mem [0:8191] = '{default: 32'h0};

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (ram_en_o && ram_we_o)
            ram_mem[ram_addr_o[14:2]] <= merge(ram_mem[ram_addr_o[14:2]], ram_wdata_o, ram_be_o);
        if (ram_en_o && !ram_we_o)
            ram_rdata_i <= ram_mem[ram_addr_o[14:2]];
    end

    // Scoreboard and counters
    resp_t sb_q[$];
    int    n_pass = 0;
    int    n_total = 0;
    int    resp_seen = 0;

    logic        s_gnt, s_ram_en, s_ram_we, s_rvalid;
    logic [3:0]  s_ram_be;
    logic [14:0] s_ram_addr;
    logic [31:0] s_ram_wdata, s_rdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
        else n_pass++;
    endtask

    // One clock: drive after the edge, sample at the falling edge, score responses and grants.
    task automatic step(input logic req, input logic we, input logic [14:0] addr,
                        input logic [3:0] be, input logic [31:0] wdata, input logic rready);
        resp_t exp_r;
        @(posedge clk); #1;
        req_i = req; we_i = we; addr_i = addr; be_i = be; wdata_i = wdata; rready_i = rready;
        #4;
        s_gnt = gnt_o; s_ram_en = ram_en_o; s_ram_we = ram_we_o; s_ram_be = ram_be_o;
        s_ram_addr = ram_addr_o; s_ram_wdata = ram_wdata_o; s_rvalid = rvalid_o; s_rdata = rdata_o;
        if (rvalid_o && rready_i) begin
            resp_seen++;
            if (sb_q.size() == 0) check("spurious_resp", 32'd1, 32'd0);
            else begin
                exp_r = sb_q.pop_front();
                check("resp_data", rdata_o, exp_r.rdata);
            end
        end
        if (gnt_o) begin
            if (we) begin
                ref_mem[addr[14:2]] = merge(ref_mem[addr[14:2]], wdata, be);
                exp_r.rdata = 32'h0;
            end else begin
                exp_r.rdata = ref_mem[addr[14:2]];
            end
            sb_q.push_back(exp_r);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 16 && sb_q.size() != 0; i++) step(1'b0, 1'b0, 15'h0, 4'h0, 32'h0, 1'b1);
        check("drain_empty", 32'(sb_q.size()), 32'd0);
    endtask

    typedef struct {
        logic        req;
        logic        we;
        logic [14:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        rready;
        logic        exp_gnt;
        logic        exp_rvalid;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [12];

    initial begin
        int gnt_cnt;
        int tries;
        logic        r_we;
        logic [14:0] r_addr;
        logic [3:0]  r_be;
        logic [31:0] r_wd;

        //              req   we    addr     be     wdata          rr    gnt   rvalid rdata
        vecs[0]  = '{1'b0, 1'b0, 15'h00, 4'h0, 32'h0,          1'b1, 1'b0, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 1'b1, 15'h10, 4'h3, 32'hA5A5_1234,  1'b1, 1'b1, 1'b0, 32'h0};
        vecs[2]  = '{1'b1, 1'b0, 15'h10, 4'h0, 32'h0,          1'b1, 1'b1, 1'b1, 32'h0};
        vecs[3]  = '{1'b0, 1'b0, 15'h00, 4'h0, 32'h0,          1'b1, 1'b0, 1'b1, 32'h0000_1234};
        vecs[4]  = '{1'b0, 1'b0, 15'h00, 4'h0, 32'h0,          1'b1, 1'b0, 1'b0, 32'h0};
        vecs[5]  = '{1'b1, 1'b1, 15'h14, 4'hF, 32'hDEAD_BEEF,  1'b0, 1'b1, 1'b0, 32'h0};
        vecs[6]  = '{1'b1, 1'b0, 15'h14, 4'h0, 32'h0,          1'b0, 1'b1, 1'b1, 32'h0};
        vecs[7]  = '{1'b1, 1'b0, 15'h10, 4'h0, 32'h0,          1'b0, 1'b0, 1'b1, 32'h0};
        vecs[8]  = '{1'b1, 1'b0, 15'h10, 4'h0, 32'h0,          1'b1, 1'b0, 1'b1, 32'h0};
        vecs[9]  = '{1'b1, 1'b0, 15'h10, 4'h0, 32'h0,          1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF};
        vecs[10] = '{1'b0, 1'b0, 15'h00, 4'h0, 32'h0,          1'b1, 1'b0, 1'b1, 32'h0000_1234};
        vecs[11] = '{1'b0, 1'b0, 15'h00, 4'h0, 32'h0,          1'b1, 1'b0, 1'b0, 32'h0};

        // Reset state
        repeat (2) @(posedge clk);
        #5;
        check("rst_gnt", 32'(gnt_o), 32'd0);
        check("rst_rvalid", 32'(rvalid_o), 32'd0);
        check("rst_rdata", rdata_o, 32'h0);
        check("rst_ram_en", 32'(ram_en_o), 32'd0);
        check("rst_ram_we", 32'(ram_we_o), 32'd0);
        check("bypass_en", 32'(ram_bypass_en_o), 32'd0);
        rstn_i = 1'b1;

        // Directed table: write/read, fall-through, backpressure to full, resume
        for (int i = 0; i < 12; i++) begin
            step(vecs[i].req, vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata, vecs[i].rready);
            check($sformatf("v%0d_gnt", i), 32'(s_gnt), 32'(vecs[i].exp_gnt));
            check($sformatf("v%0d_ram_en", i), 32'(s_ram_en), 32'(vecs[i].exp_gnt));
            check($sformatf("v%0d_ram_we", i), 32'(s_ram_we), 32'(vecs[i].exp_gnt & vecs[i].we));
            check($sformatf("v%0d_rvalid", i), 32'(s_rvalid), 32'(vecs[i].exp_rvalid));
            check($sformatf("v%0d_rdata", i), s_rdata, vecs[i].exp_rdata);
            if (vecs[i].exp_gnt) begin
                check($sformatf("v%0d_ram_addr", i), 32'(s_ram_addr), 32'(vecs[i].addr));
                check($sformatf("v%0d_ram_be", i), 32'(s_ram_be), 32'(vecs[i].be));
                check($sformatf("v%0d_ram_wdata", i), s_ram_wdata, vecs[i].wdata);
            end
        end
        drain();

        // Back-to-back: fill 8 words, then 8 consecutive reads with rready held
        for (int i = 0; i < 8; i++)
            step(1'b1, 1'b1, 15'(16'h100 + 16'(i*4)), 4'hF, 32'h1111_0000 + 32'(i), 1'b1);
        drain();
        gnt_cnt = 0;
        resp_seen = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 15'(16'h100 + 16'(i*4)), 4'h0, 32'h0, 1'b1);
            if (s_gnt) gnt_cnt++;
            check($sformatf("b2b_resp_count_%0d", i), 32'(resp_seen), 32'(i));
        end
        step(1'b0, 1'b0, 15'h0, 4'h0, 32'h0, 1'b1);
        check("b2b_grants", 32'(gnt_cnt), 32'd8);
        check("b2b_resps", 32'(resp_seen), 32'd8);
        drain();

        // Random mixed traffic with random response stalls
        for (int op = 0; op < 1000; op++) begin
            r_we   = 1'($urandom_range(0, 1));
            r_addr = 15'($urandom_range(0, 255));
            r_be   = 4'($urandom_range(0, 15));
            r_wd   = $urandom();
            tries  = 0;
            do begin
                step(1'b1, r_we, r_addr, r_be, r_wd, ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0);
                tries++;
            end while (!s_gnt && tries < 64);
            if (!s_gnt) check("grant_timeout", 32'd0, 32'd1);
            if ($urandom_range(0, 3) == 0)
                step(1'b0, 1'b0, 15'h0, 4'h0, 32'h0, ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0);
        end
        drain();

        // Reset the cycle after a read grant: its response must never appear
        step(1'b1, 1'b0, 15'h14, 4'h0, 32'h0, 1'b1);
        check("rst_read_granted", 32'(s_gnt), 32'd1);
        @(posedge clk); #1;
        rstn_i = 1'b0; req_i = 1'b0;
        sb_q.delete();
        #4;
        check("rst_mid_rvalid", 32'(rvalid_o), 32'd0);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 15'h0, 4'h0, 32'h0, 1'b1);
        rstn_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 15'h0, 4'h0, 32'h0, 1'b1);
            check($sformatf("post_rst_rvalid_%0d", i), 32'(s_rvalid), 32'd0);
        end
        step(1'b1, 1'b0, 15'h14, 4'h0, 32'h0, 1'b1);
        check("post_rst_gnt", 32'(s_gnt), 32'd1);
        step(1'b0, 1'b0, 15'h0, 4'h0, 32'h0, 1'b1);
        check("post_rst_resp_valid", 32'(s_rvalid), 32'd1);
        check("post_rst_rdata", s_rdata, ref_mem[13'h5]);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
